// File: rtl/matrix_pkg.sv
// Shared types and sizes for the matrix-multiply input loader.
// Both channels and the stream interface import this package.
package matrix_pkg;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 32;
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int MAT_ROWS = 4;
  localparam int MAT_COLS = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FILLING = 2'b01,
    FULL    = 2'b10
  } ch_state_e;

endpackage

// File: rtl/matrix_loader_if.sv
// Valid/ready byte streams for the A and X matrices.
// The source drives the master side; the loader takes the slave side.
interface matrix_loader_if
  import matrix_pkg::*;
();

  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              x_valid;
  logic [DATA_W-1:0] x_data;
  logic              x_ready;

  modport master (
    output a_valid, a_data,
    output x_valid, x_data,
    input  a_ready, x_ready
  );

  modport slave (
    input  a_valid, a_data,
    input  x_valid, x_data,
    output a_ready, x_ready
  );

endinterface

// File: rtl/matrix_loader_load_channel.sv
// One matrix channel: fill FSM, write counter, register file and
// an asynchronous read mux.
module load_channel
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              done,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  ch_state_e         state;
  ch_state_e         state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;

  assign ready  = en && (state != FULL);
  assign accept = valid && ready;
  assign done   = (state == FULL);
  assign rdata  = mem[raddr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (accept) begin
      mem[cnt] <= data;
    end
  end

  // cnt wraps to 0 on the final accept, so FULL always sits at cnt = 0
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (clr) begin
      state_nx = EMPTY;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nx = (DEPTH == 1) ? FULL : FILLING;
            cnt_nx   = cnt + 1'b1;
          end
        end
        FILLING: begin
          if (accept) begin
            cnt_nx = cnt + 1'b1;
            if (cnt == ADDR_W'(DEPTH - 1))
              state_nx = FULL;
          end
        end
        FULL: begin
          state_nx = FULL;
        end
        default: begin
          state_nx = EMPTY;
          cnt_nx   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Input stage of the matrix-multiply datapath: loads A and X
// matrices from two streams and exposes combinational read ports.
module matrix_loader
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              clear,
  matrix_loader_if.slave    s,
  output logic              aload_done,
  output logic              xload_done,
  input  logic [ADDR_W-1:0] a_raddr,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] x_raddr,
  output logic [DATA_W-1:0] x_rdata
);

  // ready is held low during clear so a same-cycle element stays unconsumed
  logic en;
  assign en = load_en && !clear;

  load_channel u_a (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clear),
    .valid (s.a_valid),
    .data  (s.a_data),
    .ready (s.a_ready),
    .done  (aload_done),
    .raddr (a_raddr),
    .rdata (a_rdata)
  );

  load_channel u_x (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clear),
    .valid (s.x_valid),
    .data  (s.x_data),
    .ready (s.x_ready),
    .done  (xload_done),
    .raddr (x_raddr),
    .rdata (x_rdata)
  );

endmodule

// File: tb/tb_matrix_loader.sv
// Directed scoreboard bench for matrix_loader.
// Accepted elements are queued with their address and checked via read ports.
module tb_matrix_loader;
  import matrix_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 0;
  logic rst, load_en, clear;
  logic aload_done, xload_done;
  logic [ADDR_W-1:0] a_raddr, x_raddr;
  logic [DATA_W-1:0] a_rdata, x_rdata;

  matrix_loader_if ifc ();

  matrix_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .clear      (clear),
    .s          (ifc.slave),
    .aload_done (aload_done),
    .xload_done (xload_done),
    .a_raddr    (a_raddr),
    .a_rdata    (a_rdata),
    .x_raddr    (x_raddr),
    .x_rdata    (x_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  exp_t qa[$];
  exp_t qx[$];
  logic [DATA_W-1:0] model_a [DEPTH];
  logic [DATA_W-1:0] model_x [DEPTH];
  int na, nx;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // called #1 after inputs are driven, before the accepting edge
  task automatic note_accepts();
    exp_t e;
    if (ifc.a_valid && ifc.a_ready) begin
      e.addr = ADDR_W'(na);
      e.data = ifc.a_data;
      qa.push_back(e);
      model_a[na] = ifc.a_data;
      na = (na + 1) % DEPTH;
    end
    if (ifc.x_valid && ifc.x_ready) begin
      e.addr = ADDR_W'(nx);
      e.data = ifc.x_data;
      qx.push_back(e);
      model_x[nx] = ifc.x_data;
      nx = (nx + 1) % DEPTH;
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (qa.size() > 0) begin
      e = qa.pop_front();
      a_raddr = e.addr;
      #1;
      check({tag, "_a_rd"}, a_rdata, e.data);
    end
    while (qx.size() > 0) begin
      e = qx.pop_front();
      x_raddr = e.addr;
      #1;
      check({tag, "_x_rd"}, x_rdata, e.data);
    end
  endtask

  task automatic pulse_clear();
    ifc.a_valid = 0;
    ifc.x_valid = 0;
    clear = 1;
    tick();
    clear = 0;
    na = 0;
    nx = 0;
    #1;
    check("clr_adone", aload_done, 0);
    check("clr_xdone", xload_done, 0);
  endtask

  initial begin
    int cyc, a_t, x_t;
    rst = 1; load_en = 0; clear = 0;
    ifc.a_valid = 0; ifc.a_data = 0;
    ifc.x_valid = 0; ifc.x_data = 0;
    a_raddr = 0; x_raddr = 0;
    na = 0; nx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      model_a[i] = 0;
      model_x[i] = 0;
    end
    tick();
    tick();
    check("rst_aready", ifc.a_ready, 0);
    check("rst_xready", ifc.x_ready, 0);
    check("rst_adone", aload_done, 0);
    check("rst_xdone", xload_done, 0);
    check("rst_ard", a_rdata, 0);
    rst = 0;

    // 1: both streams at full rate, data = address + 1
    load_en = 1;
    ifc.a_valid = 1;
    ifc.x_valid = 1;
    for (int k = 0; k < DEPTH; k++) begin
      ifc.a_data = DATA_W'(k + 1);
      ifc.x_data = DATA_W'(k + 1);
      #1;
      check("t1_aready", ifc.a_ready, 1);
      check("t1_xready", ifc.x_ready, 1);
      if (k == DEPTH - 1) check("t1_adone_early", aload_done, 0);
      note_accepts();
      tick();
    end
    check("t1_adone", aload_done, 1);
    check("t1_xdone", xload_done, 1);
    check("t1_aready_full", ifc.a_ready, 0);
    check("t1_xready_full", ifc.x_ready, 0);
    a_raddr = 31;
    x_raddr = 0;
    #1;
    check("t1_a31", a_rdata, 32);
    check("t1_x0", x_rdata, 1);
    drain("t1");

    // 2: A every cycle, X every third cycle
    pulse_clear();
    a_t = -1;
    x_t = -1;
    cyc = 0;
    while (!(aload_done && xload_done) && cyc < 300) begin
      if (aload_done && a_t < 0) a_t = cyc;
      if (xload_done && x_t < 0) x_t = cyc;
      ifc.a_valid = 1;
      ifc.a_data = DATA_W'($urandom);
      ifc.x_valid = (cyc % 3 == 0);
      ifc.x_data = DATA_W'($urandom);
      #1;
      if (a_t >= 0) begin
        check("t2_adone_sticky", aload_done, 1);
        check("t2_aready_full", ifc.a_ready, 0);
      end
      note_accepts();
      tick();
      cyc++;
    end
    if (x_t < 0 && xload_done) x_t = cyc;
    check("t2_finished", aload_done && xload_done, 1);
    check("t2_a_time", a_t, 32);
    check("t2_gap", x_t - a_t, 62);
    ifc.a_valid = 0;
    ifc.x_valid = 0;
    drain("t2");

    // 3: load_en gap after 10 A elements
    pulse_clear();
    for (int k = 0; k < 10; k++) begin
      ifc.a_valid = 1;
      ifc.a_data = DATA_W'($urandom);
      #1;
      note_accepts();
      tick();
    end
    load_en = 0;
    ifc.a_data = ~model_a[10];
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_gap_ready", ifc.a_ready, 0);
      tick();
    end
    a_raddr = 10;
    #1;
    check("t3_gap_nowrite", a_rdata, model_a[10]);
    load_en = 1;
    cyc = 0;
    while (!aload_done && cyc < 40) begin
      ifc.a_data = DATA_W'($urandom);
      #1;
      if (ifc.a_ready && na == DEPTH - 1)
        check("t3_done_early", aload_done, 0);
      note_accepts();
      tick();
      cyc++;
    end
    check("t3_adone", aload_done, 1);
    check("t3_cycles", cyc, 22);
    ifc.a_valid = 0;
    ifc.x_valid = 1;
    cyc = 0;
    while (!xload_done && cyc < 40) begin
      ifc.x_data = DATA_W'($urandom);
      #1;
      note_accepts();
      tick();
      cyc++;
    end
    ifc.x_valid = 0;
    check("t3_xdone", xload_done, 1);
    drain("t3");

    // 4: clear with a same-cycle A valid
    ifc.a_valid = 1;
    ifc.a_data = ~model_a[0];
    clear = 1;
    #1;
    check("t4_clr_aready", ifc.a_ready, 0);
    check("t4_clr_xready", ifc.x_ready, 0);
    note_accepts();
    tick();
    clear = 0;
    ifc.a_valid = 0;
    na = 0;
    nx = 0;
    a_raddr = 0;
    #1;
    check("t4_adone", aload_done, 0);
    check("t4_xdone", xload_done, 0);
    check("t4_nowrite", a_rdata, model_a[0]);
    for (int k = 0; k < 3; k++) begin
      ifc.a_valid = 1;
      ifc.a_data = ~model_a[k];
      #1;
      note_accepts();
      tick();
    end
    ifc.a_valid = 0;
    a_raddr = 3;
    #1;
    check("t4_retain", a_rdata, model_a[3]);
    drain("t4");

    // 5: reset in the middle of an X fill
    pulse_clear();
    ifc.x_valid = 1;
    for (int k = 0; k < 17; k++) begin
      ifc.x_data = DATA_W'(k + 8'h40);
      #1;
      note_accepts();
      tick();
    end
    qx.delete();
    rst = 1;
    load_en = 0;
    tick();
    rst = 0;
    na = 0;
    nx = 0;
    #1;
    check("t5_xready", ifc.x_ready, 0);
    check("t5_adone", aload_done, 0);
    check("t5_xdone", xload_done, 0);
    for (int i = 0; i < DEPTH; i++) begin
      a_raddr = ADDR_W'(i);
      x_raddr = ADDR_W'(i);
      model_a[i] = 0;
      model_x[i] = 0;
      #1;
      check("t5_a_zero", a_rdata, 0);
      check("t5_x_zero", x_rdata, 0);
    end
    ifc.x_valid = 0;

    // 6: write and read of A address 5 in the same cycle
    load_en = 1;
    ifc.a_valid = 1;
    for (int k = 0; k < 5; k++) begin
      ifc.a_data = DATA_W'(k + 8'h10);
      #1;
      note_accepts();
      tick();
    end
    ifc.a_data = 8'hAB;
    a_raddr = 5;
    #1;
    check("t6_ready", ifc.a_ready, 1);
    check("t6_old", a_rdata, 8'h00);
    note_accepts();
    tick();
    ifc.a_valid = 0;
    check("t6_new", a_rdata, 8'hAB);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
